// File: rtl/pc_fetch_if.sv
// Program-memory read port for pc_fetch: byte-wide req/ack handshake.
// The master (pc_fetch) drives the request and address; the slave (memory) returns data.
interface pc_fetch_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch sequencer: fetches opcode (+ optional immediate),
// holds it for execution, then continues sequentially or loads the jump target.
module pc_fetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  pc_fetch_if.master        mem,
  output logic [7:0]        ins,
  output logic              ins_valid,
  input  logic              imm_needed,
  output logic [7:0]        imm,
  output logic              imm_valid,
  input  logic              exec_done,
  input  logic              pcoe,
  input  logic [ADDR_W-1:0] pcout,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {
    StIdle,
    StFetchIns,
    StDecode,
    StFetchImm,
    StExec
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              req_q;
  logic [7:0]        ins_q;
  logic              ins_valid_q;
  logic [7:0]        imm_q;
  logic              imm_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      ins_q       <= 8'h00;
      ins_valid_q <= 1'b0;
      imm_q       <= 8'h00;
      imm_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q <= StFetchIns;
            req_q   <= 1'b1;
          end
        end
        StFetchIns: begin
          if (mem.mem_ack) begin
            ins_q       <= mem.mem_data;
            pc_q        <= pc_q + ADDR_W'(1);
            req_q       <= 1'b0;
            ins_valid_q <= 1'b1;
            imm_valid_q <= 1'b0;
            state_q     <= StDecode;
          end
        end
        StDecode: begin
          if (imm_needed) begin
            state_q <= StFetchImm;
            req_q   <= 1'b1;
          end else begin
            state_q <= StExec;
          end
        end
        StFetchImm: begin
          if (mem.mem_ack) begin
            imm_q       <= mem.mem_data;
            pc_q        <= pc_q + ADDR_W'(1);
            req_q       <= 1'b0;
            imm_valid_q <= 1'b1;
            state_q     <= StExec;
          end
        end
        StExec: begin
          // pc already points past the instruction; only a taken branch overrides it
          if (exec_done) begin
            if (pcoe) begin
              pc_q <= pcout;
            end
            ins_valid_q <= 1'b0;
            imm_valid_q <= 1'b0;
            if (run) begin
              state_q <= StFetchIns;
              req_q   <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = pc_q;
  assign pc           = pc_q;
  assign ins          = ins_q;
  assign ins_valid    = ins_valid_q;
  assign imm          = imm_q;
  assign imm_valid    = imm_valid_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch: an instruction-trace model predicts every fetch and
// every presented instruction; a negedge monitor compares the DUT against that trace.
module tb_pc_fetch;

  localparam int unsigned      N        = 150;
  localparam logic [7:0]       RESET_PC = 8'hFF;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] op;
    logic       has_imm;
    logic [7:0] imm;
    logic [7:0] pc_after;
    logic       br;
    logic [7:0] tgt;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] ins;
  logic       ins_valid;
  logic       imm_needed;
  logic [7:0] imm;
  logic       imm_valid;
  logic       exec_done;
  logic       pcoe;
  logic [7:0] pcout;
  logic [7:0] pc;

  pc_fetch_if #(.ADDR_W(8)) mem_if ();

  pc_fetch #(
    .ADDR_W   (8),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .mem        (mem_if),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .imm_needed (imm_needed),
    .imm        (imm),
    .imm_valid  (imm_valid),
    .exec_done  (exec_done),
    .pcoe       (pcoe),
    .pcout      (pcout),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  rec_t       plan [N];
  rec_t       exp_q [$];
  rec_t       cur;

  int n_vec = 0;
  int n_err = 0;
  int ret_idx = 0;
  int fetch_idx = 0;
  bit go = 1'b0;
  bit stop = 1'b0;

  // monitor bookkeeping
  logic       prev_ins_hs = 1'b0;
  logic       prev_retire = 1'b0;
  logic       prev_run = 1'b0;
  logic       hs, in_exec, retire;
  logic [7:0] a1;

  // Decoder rule used by both the stimulus and the model: odd opcodes carry an immediate.
  function automatic logic needs_imm(input logic [7:0] op);
    return op[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'(RESET_PC));
    chk({tag, "_mem_req"}, 32'(mem_if.mem_req), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_if.mem_addr), 32'(RESET_PC));
    chk({tag, "_ins"}, 32'(ins), 32'd0);
    chk({tag, "_ins_valid"}, 32'(ins_valid), 32'd0);
    chk({tag, "_imm"}, 32'(imm), 32'd0);
    chk({tag, "_imm_valid"}, 32'(imm_valid), 32'd0);
  endtask

  // Instruction-level reference: walk the program from RESET_PC, consuming 1 or 2 bytes per
  // instruction and following the randomly chosen branch decisions.
  task automatic build_trace();
    logic [7:0] m_pc;
    logic [7:0] p;
    rec_t       r;
    m_pc = RESET_PC;
    for (int k = 0; k < int'(N); k++) begin
      r.addr    = m_pc;
      r.op      = mem[m_pc];
      p         = m_pc + 8'd1;
      r.has_imm = needs_imm(r.op);
      r.imm     = 8'h00;
      if (r.has_imm) begin
        r.imm = mem[p];
        p     = p + 8'd1;
      end
      r.pc_after = p;
      r.br       = ($urandom_range(3) == 0);
      case ($urandom_range(7))
        0:       r.tgt = r.addr;
        1:       r.tgt = 8'hFF;
        default: r.tgt = 8'($urandom_range(255));
      endcase
      m_pc    = r.br ? r.tgt : r.pc_after;
      plan[k] = r;
      exp_q.push_back(r);
    end
  endtask

  // Monitor: values seen at negedge are exactly what the next rising edge acts on.
  always @(negedge clk) begin
    if (go && !stop && !reset) begin
      if (prev_ins_hs) begin
        a1 = cur.addr + 8'd1;
        chk("decode_ins", 32'(ins), 32'(cur.op));
        chk("decode_ins_valid", 32'(ins_valid), 32'd1);
        chk("decode_imm_valid", 32'(imm_valid), 32'd0);
        chk("decode_pc", 32'(pc), 32'(a1));
      end
      if (prev_retire) begin
        chk("after_exec_req_follows_run", 32'(mem_if.mem_req), 32'(prev_run));
        chk("after_exec_ins_valid", 32'(ins_valid), 32'd0);
      end
      in_exec = ins_valid && !mem_if.mem_req && !prev_ins_hs;
      if (in_exec) begin
        chk("exec_ins", 32'(ins), 32'(cur.op));
        chk("exec_imm_valid", 32'(imm_valid), 32'(cur.has_imm));
        if (cur.has_imm) chk("exec_imm", 32'(imm), 32'(cur.imm));
        chk("exec_pc", 32'(pc), 32'(cur.pc_after));
      end
      hs = mem_if.mem_req && mem_if.mem_ack;
      if (hs && !ins_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fetch", 32'(exp_q.size()), 32'd1);
        end else begin
          cur = exp_q.pop_front();
          chk("fetch_addr", 32'(mem_if.mem_addr), 32'(cur.addr));
          fetch_idx++;
        end
      end
      if (hs && ins_valid) begin
        a1 = cur.addr + 8'd1;
        chk("imm_fetch_expected", 32'd1, 32'(cur.has_imm));
        chk("imm_fetch_addr", 32'(mem_if.mem_addr), 32'(a1));
      end
      retire = in_exec && exec_done;
      if (retire) ret_idx++;
      prev_ins_hs = hs && !ins_valid;
      prev_retire = retire;
      prev_run    = run;
    end
  end

  // Driver: memory responder, decoder and execution unit with random timing.
  initial begin : drv
    wait (go);
    while (!stop) begin
      @(posedge clk);
      #1;
      if (stop) break;
      run        = (fetch_idx >= int'(N)) ? 1'b0 : ($urandom_range(7) != 0);
      imm_needed = ins_valid ? needs_imm(ins) : 1'($urandom_range(1));
      exec_done  = ($urandom_range(2) == 0);
      if (exec_done && ret_idx < int'(N)) begin
        pcoe  = plan[ret_idx].br;
        pcout = plan[ret_idx].tgt;
      end else begin
        pcoe  = 1'($urandom_range(1));
        pcout = 8'($urandom_range(255));
      end
      if (mem_if.mem_req) mem_if.mem_ack = ($urandom_range(2) == 0);
      else                mem_if.mem_ack = ($urandom_range(4) == 0);
      mem_if.mem_data = (mem_if.mem_req && mem_if.mem_ack) ? mem[mem_if.mem_addr]
                                                            : 8'($urandom_range(255));
    end
  end

  initial begin : main
    int cyc;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(255));
    mem[8'hFF] = 8'h41;
    mem[8'h00] = 8'hAB;
    build_trace();

    reset           = 1'b1;
    run             = 1'b0;
    imm_needed      = 1'b0;
    exec_done       = 1'b0;
    pcoe            = 1'b0;
    pcout           = 8'h00;
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    go    = 1'b1;

    cyc = 0;
    while (ret_idx < int'(N) && cyc < 40000) begin
      @(posedge clk);
      cyc++;
    end
    chk("all_instructions_retired", 32'(ret_idx), 32'(N));
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle_after_run_low", 32'(mem_if.mem_req), 32'd0);
    chk("trace_consumed", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of an opcode handshake, then a late ack.
    stop = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run            = 1'b1;
    exec_done      = 1'b0;
    mem_if.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_req", 32'(mem_if.mem_req), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run   = 1'b0;
    @(posedge clk);
    #1;
    reset           = 1'b0;
    mem_if.mem_ack  = 1'b1;
    mem_if.mem_data = 8'h5A;
    @(negedge clk);
    check_reset_vals("mid_fetch_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("late_ack");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Program counter and instruction-fetch sequencer for the 8-bit CPU. It is the consumer of the jump unit's pcoe/pcout pair: it fetches the opcode byte, and optionally one immediate byte, from byte-wide program memory over a req/ack handshake. It presents them to the decoder, waits for execution to finish, then either loads the jump target or continues sequentially. The jump unit reads the current PC from this block's pc output.

Parameters:
ADDR_W, 8, width of the program counter and memory address (wraps modulo 2^ADDR_W)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous active-high reset
run  input  1  enable instruction fetching; sampled in IDLE and at instruction end
mem_req  output  1  program-memory read request
mem_addr  output  ADDR_W  read address, valid while mem_req=1
mem_ack  input  1  memory has data on mem_data; meaningful only while mem_req=1
mem_data  input  8  read data, captured on mem_ack
ins  output  8  latched opcode byte
ins_valid  output  1  ins valid for decoder
imm_needed  input  1  decoder: current opcode carries an immediate byte; sampled in DECODE only
imm  output  8  latched immediate byte
imm_valid  output  1  imm valid for current instruction
exec_done  input  1  execution of current instruction complete; sampled in EXEC only
pcoe  input  1  jump unit: take branch; sampled only when exec_done=1 in EXEC
pcout  input  ADDR_W  jump target
pc  output  ADDR_W  current program counter (address of next byte to fetch)

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, mem_req=0, mem_addr=RESET_PC, ins=0, ins_valid=0, imm=0, imm_valid=0.
- Reset has priority over every other input. Reset mid-handshake drops mem_req on the next edge. A late mem_ack after reset is ignored.
- All outputs are registered. mem_addr always equals pc.
- States: IDLE, FETCH_INS, DECODE, FETCH_IMM, EXEC.
- IDLE: mem_req=0. If run=1, go to FETCH_INS (mem_req=1 from the next cycle).
- FETCH_INS: mem_req=1 until a cycle with mem_ack=1. On that cycle:
  - ins<=mem_data, pc<=pc+1, mem_req<=0, ins_valid<=1, imm_valid<=0.
  - Go to DECODE.
  - Minimum latency is 1 cycle from mem_req high to capture, when ack is already high.
- DECODE: exactly one cycle. If imm_needed=1, go to FETCH_IMM with mem_req<=1. Otherwise go to EXEC.
- FETCH_IMM: same handshake as FETCH_INS. On ack: imm<=mem_data, pc<=pc+1, imm_valid<=1, mem_req<=0, go to EXEC.
- EXEC: hold ins, ins_valid and imm/imm_valid stable. Wait for exec_done=1. On that cycle:
  - If pcoe=1, pc<=pcout; otherwise pc is unchanged (already points past the instruction).
  - ins_valid<=0, imm_valid<=0.
  - If run=1, go to FETCH_INS (mem_req<=1); else go to IDLE.
- exec_done in the same cycle EXEC is entered is accepted: one-cycle EXEC.
- pcoe/pcout are ignored outside that exec_done cycle.
- run deasserted mid-instruction: the instruction completes; the block stops in IDLE afterwards.
- pc increment wraps 2^ADDR_W-1 -> 0. A jump to any value, including the current pc, is legal.
- mem_ack while mem_req=0 has no effect. mem_data is sampled only on the ack cycle.
- Back-to-back throughput with ack tied high and exec_done tied high:
  - no immediate: 3 cycles per instruction (FETCH_INS, DECODE, EXEC);
  - with immediate: 4 cycles.
- Decoder, ALU and flags are outside this block. Jump decision comes only via pcoe.

Test Plan:
- Reset then run=1, mem_ack tied 1, memory returns 0x10,0x20,0x30, imm_needed=0, exec_done=1 -> pc 0->1->2->3; ins shows 0x10,0x20,0x30; ins_valid pulses; new instruction every 3 cycles.
- Opcode 0x41 with imm_needed=1, memory[1]=0xAB, mem_ack delayed 3 cycles each fetch -> mem_req held high through each wait; imm=0xAB and imm_valid=1 in EXEC; pc=2 after.
- Jump: at pc=5, exec_done=1 with pcoe=1, pcout=0x80 -> next mem_addr=0x80. Same with pcoe=0 -> next mem_addr=0x06. pcoe=1 while exec_done=0 -> no effect.
- Wrap: start RESET_PC=0xFF, one-byte instruction, no jump -> next fetch at 0x00.
- run dropped during FETCH_IMM -> instruction completes, then IDLE with mem_req=0. Re-assert run -> fetch resumes at the saved pc.
- Assert reset in FETCH_INS with mem_req=1, then pulse mem_ack after reset -> all outputs at reset values, pc=RESET_PC, ack ignored.
